// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for exec_sequencer: opcodes, FSM state codes, flag bit positions
// and small opcode-classification helpers.
package exec_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_JMP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_LSL = 4'h3,
    OP_LSR = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_LD  = 4'h8, OP_ST  = 4'h9, OP_MOV = 4'hA, OP_BEQ = 4'hB,
    OP_BNE = 4'hC, OP_BLT = 4'hD, OP_BGT = 4'hE, OP_CMP = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  function automatic logic is_branch(input op_e op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGT};
  endfunction

  function automatic logic is_mem(input op_e op);
    return op inside {OP_LD, OP_ST};
  endfunction

  function automatic logic writes_reg(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LD};
  endfunction

  // Ops that enable ALU flag generation and commit flags in writeback (CMP behaves as SUB)
  function automatic logic updates_flags(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_CMP};
  endfunction

  function automatic logic branch_taken(input op_e op, input logic [3:0] f);
    logic taken;
    case (op)
      OP_BEQ:  taken = f[FLG_Z];
      OP_BNE:  taken = !f[FLG_Z];
      OP_BLT:  taken = f[FLG_N] && !f[FLG_Z];
      OP_BGT:  taken = !f[FLG_N] && !f[FLG_Z];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exec_sequencer_reg_file.sv
// 16-entry register file: three async read ports (rs, rt, rd), one sync write port,
// async clear; R0 optionally hardwired to zero.
module exec_sequencer_reg_file #(
  parameter int DATA_W  = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ra_addr,
  input  logic [3:0]        rb_addr,
  input  logic [3:0]        rc_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rc_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_r [16];

  // Write port; writes to R0 are dropped when it is hardwired to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else if (wr_en && !(R0_ZERO && (wr_addr == 4'd0))) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  assign ra_data = (R0_ZERO && (ra_addr == 4'd0)) ? {DATA_W{1'b0}} : regs_r[ra_addr];
  assign rb_data = (R0_ZERO && (rb_addr == 4'd0)) ? {DATA_W{1'b0}} : regs_r[rb_addr];
  assign rc_data = (R0_ZERO && (rc_addr == 4'd0)) ? {DATA_W{1'b0}} : regs_r[rc_addr];

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer driving an external 16-bit ALU and a shared memory port.
// Optional EXEC_SEQ_HALT_EN: a JMP to its own address parks the core in HALT.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        alu_func,
  output logic [DATA_W-1:0] alu_op0,
  output logic [DATA_W-1:0] alu_op1,
  output logic              alu_flag_en,
  output logic [3:0]        alu_flag_in,
  input  logic [DATA_W-1:0] alu_q,
  input  logic [3:0]        alu_flag_out,
  output logic [15:0]       pc,
  output logic [3:0]        flags,
  output logic              halted
);

  state_e            state_r;
  logic [15:0]       ir_r;
  logic [DATA_W-1:0] q_r;
  logic [3:0]        fo_r;
  logic [DATA_W-1:0] ld_r;
  op_e               op_s;
  logic [DATA_W-1:0] rs_data_s, rt_data_s, rd_data_s;
  logic [15:0]       br_target_s, next_pc_s;
  logic              halt_s;

  assign op_s        = op_e'(ir_r[15:12]);
  assign br_target_s = pc + 16'd1 + {{4{ir_r[11]}}, ir_r[11:0]};

  exec_sequencer_reg_file #(.DATA_W(DATA_W), .R0_ZERO(R0_ZERO)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ir_r[7:4]),
    .rb_addr (ir_r[3:0]),
    .rc_addr (ir_r[11:8]),
    .ra_data (rs_data_s),
    .rb_data (rt_data_s),
    .rc_data (rd_data_s),
    .wr_en   ((state_r == S_WB) && writes_reg(op_s)),
    .wr_addr (ir_r[11:8]),
    .wr_data ((op_s == OP_LD) ? ld_r : q_r)
  );

  // Program-counter successor chosen in writeback
  always_comb begin
    next_pc_s = pc + 16'd1;
    if (op_s == OP_JMP) begin
      next_pc_s = q_r;
    end else if (is_branch(op_s) && branch_taken(op_s, flags)) begin
      next_pc_s = q_r;
    end else begin
      next_pc_s = pc + 16'd1;
    end
  end

`ifdef EXEC_SEQ_HALT_EN
  assign halt_s = (op_s == OP_JMP) && (q_r == pc);

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else     halted <= halted || ((state_r == S_WB) && halt_s);
  end
`else
  assign halt_s = 1'b0;
  assign halted = 1'b0;
`endif

  // Main sequencer FSM with registered memory and ALU outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_FETCH;
      pc          <= RESET_PC;
      flags       <= 4'h0;
      ir_r        <= 16'h0000;
      q_r         <= {DATA_W{1'b0}};
      fo_r        <= 4'h0;
      ld_r        <= {DATA_W{1'b0}};
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= {DATA_W{1'b0}};
      alu_func    <= 4'h0;
      alu_op0     <= {DATA_W{1'b0}};
      alu_op1     <= {DATA_W{1'b0}};
      alu_flag_en <= 1'b0;
      alu_flag_in <= 4'h0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (mem_req && mem_ack) begin
            ir_r    <= mem_rdata;
            mem_req <= 1'b0;
            state_r <= S_DECODE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_DECODE: begin
          alu_func    <= ir_r[15:12];
          alu_flag_in <= (op_s == OP_LD) ? {1'b0, flags[2:0]} : flags;
          case (op_s)
            OP_MOV: begin
              alu_op0     <= {8'h00, ir_r[7:0]};
              alu_op1     <= 16'h0000;
              alu_flag_en <= 1'b0;
            end
            OP_LD, OP_ST: begin
              alu_op0     <= rs_data_s;
              alu_op1     <= {12'h000, ir_r[3:0]};
              alu_flag_en <= 1'b0;
            end
            OP_JMP: begin
              alu_op0     <= rs_data_s;
              alu_op1     <= 16'h0000;
              alu_flag_en <= 1'b0;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT: begin
              alu_op0     <= br_target_s;
              alu_op1     <= 16'h0000;
              alu_flag_en <= 1'b0;
            end
            default: begin
              alu_op0     <= rs_data_s;
              alu_op1     <= rt_data_s;
              alu_flag_en <= 1'b1;
            end
          endcase
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          q_r  <= alu_q;
          fo_r <= alu_flag_out;
          if (is_mem(op_s)) begin
            mem_req   <= 1'b1;
            mem_we    <= (op_s == OP_ST);
            mem_addr  <= alu_q;
            mem_wdata <= rd_data_s;
            state_r   <= S_MEM;
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            ld_r    <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state_r <= S_WB;
          end
        end
        S_WB: begin
          if (updates_flags(op_s)) flags <= fo_r;
          pc <= next_pc_s;
          if (halt_s) begin
            state_r <= S_HALT;
            mem_req <= 1'b0;
          end else begin
            state_r  <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= next_pc_s;
          end
        end
        S_HALT: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: begin
          state_r <= S_FETCH;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: behavioural ALU model plus a handshake responder
// whose instruction/data words and ack delays are given step by step.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  alu_func, alu_flag_in, alu_flag_out, flags;
  logic [15:0] alu_op0, alu_op1, alu_q, pc;
  logic        alu_flag_en, halted;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_req  = 0;
  int t0     = 0;

  exec_sequencer #(.DATA_W(16), .RESET_PC(16'h0000), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_func(alu_func), .alu_op0(alu_op0), .alu_op1(alu_op1),
    .alu_flag_en(alu_flag_en), .alu_flag_in(alu_flag_in),
    .alu_q(alu_q), .alu_flag_out(alu_flag_out),
    .pc(pc), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: ADD-style for non-logic funcs, SUB/CMP with carry = no-borrow
  logic [16:0] sum;
  logic        c_f, v_f;
  always_comb begin
    sum   = {1'b0, alu_op0} + {1'b0, alu_op1};
    c_f   = sum[16];
    v_f   = (alu_op0[15] == alu_op1[15]) && (sum[15] != alu_op0[15]);
    alu_q = sum[15:0];
    case (alu_func)
      4'h2, 4'hF: begin
        sum   = {1'b0, alu_op0} + {1'b0, ~alu_op1} + 17'd1;
        c_f   = sum[16];
        v_f   = (alu_op0[15] != alu_op1[15]) && (sum[15] != alu_op0[15]);
        alu_q = sum[15:0];
      end
      4'h3: begin alu_q = alu_op0 << alu_op1[3:0]; c_f = 1'b0; v_f = 1'b0; end
      4'h4: begin alu_q = alu_op0 >> alu_op1[3:0]; c_f = 1'b0; v_f = 1'b0; end
      4'h5: begin alu_q = alu_op0 & alu_op1; c_f = 1'b0; v_f = 1'b0; end
      4'h6: begin alu_q = alu_op0 | alu_op1; c_f = 1'b0; v_f = 1'b0; end
      4'h7: begin alu_q = alu_op0 ^ alu_op1; c_f = 1'b0; v_f = 1'b0; end
      default: ;
    endcase
    alu_flag_out = alu_flag_en ? {c_f, alu_q[15], v_f, (alu_q == 16'h0000)} : alu_flag_in;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req"}, 16'(mem_req), 16'h0001);
  endtask

  // Answer one transfer: checks address/we/wdata stay stable until ack after dly cycles
  task automatic serve(input string tag, input logic [15:0] addr, input logic we,
                       input logic [15:0] wdata, input logic [15:0] rdata, input int dly);
    wait_req(tag);
    t_req = cyc;
    for (int i = 1; i <= dly; i++) begin
      chk({tag, " addr"}, mem_addr, addr);
      chk({tag, " we"}, 16'(mem_we), 16'(we));
      if (we) chk({tag, " wdata"}, mem_wdata, wdata);
      if (i == dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk({tag, " req drop"}, 16'(mem_req), 16'h0000);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst mem_req", 16'(mem_req), 16'h0000);
    chk("rst alu_op0", alu_op0, 16'h0000);
    chk("rst alu_func", 16'(alu_func), 16'h0000);
    chk("rst halted", 16'(halted), 16'h0000);

    rst = 1'b0;
    @(negedge clk);
    chk("boot mem_req", 16'(mem_req), 16'h0001);
    chk("boot mem_addr", mem_addr, 16'h0000);
    chk("boot pc", pc, 16'h0000);
    chk("boot flags", 16'(flags), 16'h0000);

    serve("f0 MOV", 16'h0000, 1'b0, 16'h0000, 16'hA105, 1);
    t0 = t_req;
    serve("f1 ADD", 16'h0001, 1'b0, 16'h0000, 16'h1211, 1);
    chk("MOV cycles", 16'(t_req - t0), 16'd4);
    t0 = t_req;
    serve("f2 CMP", 16'h0002, 1'b0, 16'h0000, 16'hF011, 1);
    chk("ADD cycles", 16'(t_req - t0), 16'd4);
    chk("pc after ADD", pc, 16'h0002);
    chk("flags after ADD", 16'(flags), 16'h0000);

    serve("f3 BEQ", 16'h0003, 1'b0, 16'h0000, 16'hB003, 1);
    chk("flags after CMP", 16'(flags), 16'h0009);
    serve("f7 BNE", 16'h0007, 1'b0, 16'h0000, 16'hC003, 1);
    chk("pc BEQ taken", pc, 16'h0007);

    serve("f8 ST", 16'h0008, 1'b0, 16'h0000, 16'h9104, 1);
    chk("pc BNE not taken", pc, 16'h0008);
    t0 = t_req;
    serve("d ST R1", 16'h0004, 1'b1, 16'h0005, 16'h0000, 3);
    chk("ST flag_in", 16'(alu_flag_in), 16'h0009);
    chk("ST op1", alu_op1, 16'h0004);

    serve("f9 LD", 16'h0009, 1'b0, 16'h0000, 16'h8304, 1);
    chk("ST cycles", 16'(t_req - t0), 16'd7);
    serve("d LD R3", 16'h0004, 1'b0, 16'h0000, 16'h0005, 1);
    chk("LD flag_in", 16'(alu_flag_in), 16'h0001);
    chk("LD func", 16'(alu_func), 16'h0008);

    serve("f10 ST", 16'h000A, 1'b0, 16'h0000, 16'h9306, 1);
    chk("flags after LD", 16'(flags), 16'h0009);
    serve("d ST R3", 16'h0006, 1'b1, 16'h0005, 16'h0000, 1);
    serve("f11 ST", 16'h000B, 1'b0, 16'h0000, 16'h9207, 1);
    serve("d ST R2", 16'h0007, 1'b1, 16'h000A, 16'h0000, 1);

    serve("f12 ST", 16'h000C, 1'b0, 16'h0000, 16'h9108, 1);
    wait_req("d ST abort");
    chk("abort addr", mem_addr, 16'h0008);
    chk("abort we", 16'(mem_we), 16'h0001);
    #2 rst = 1'b1;
    #1;
    chk("async rst mem_req", 16'(mem_req), 16'h0000);
    chk("async rst mem_we", 16'(mem_we), 16'h0000);
    chk("async rst pc", pc, 16'h0000);
    chk("async rst flags", 16'(flags), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reboot mem_req", 16'(mem_req), 16'h0001);

    serve("r0 JMP", 16'h0000, 1'b0, 16'h0000, 16'h0000, 1);
`ifdef EXEC_SEQ_HALT_EN
    repeat (4) @(negedge clk);
    chk("halt halted", 16'(halted), 16'h0001);
    chk("halt mem_req", 16'(mem_req), 16'h0000);
    repeat (6) @(negedge clk);
    chk("halt stays", 16'(mem_req), 16'h0000);
`else
    t0 = t_req;
    serve("r1 JMP", 16'h0000, 1'b0, 16'h0000, 16'h0000, 1);
    chk("self-jump cycles 1", 16'(t_req - t0), 16'd4);
    t0 = t_req;
    serve("r2 JMP", 16'h0000, 1'b0, 16'h0000, 16'h0000, 1);
    chk("self-jump cycles 2", 16'(t_req - t0), 16'd4);
    chk("no halt", 16'(halted), 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
